// File: rtl/pfu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pfu : rv32i prefetch unit - word fetch, small instruction FIFO, dav/ack to id
// Optional PFU_ALIGN_CHECK_EN: misaligned vector target yields one ferr entry.
// Rev 1.0
// ---------------------------------------------------------------------------
`ifndef SOFID_RANGE
`define SOFID_RANGE 1:0
`define SOFID_RUN   2'b00
`define SOFID_JUMP  2'b01
`endif

module pfu #(
  parameter int                C_XLEN         = 32,
  parameter int                C_FIFO_DEPTH_X = 2,
  parameter logic [C_XLEN-1:0] C_RESET_VECTOR = '0
) (
  input  logic                 clk_i,
  input  logic                 clk_en_i,
  input  logic                 resetb_i,
  input  logic                 exs_pc_wr_i,
  input  logic [C_XLEN-1:0]    exs_pc_i,
  output logic                 ids_dav_o,
  input  logic                 ids_ack_i,
  output logic [`SOFID_RANGE]  ids_sofid_o,
  output logic [31:0]          ids_ins_o,
  output logic                 ids_ferr_o,
  output logic [C_XLEN-1:0]    ids_pc_o,
  output logic                 imem_req_o,
  input  logic                 imem_gnt_i,
  output logic [C_XLEN-1:0]    imem_addr_o,
  input  logic                 imem_rvalid_i,
  input  logic [31:0]          imem_rdata_i,
  input  logic                 imem_rerr_i
);

  localparam int               C_DEPTH   = 1 << C_FIFO_DEPTH_X;
  localparam int               C_CW      = C_FIFO_DEPTH_X + 1;
  localparam logic [C_CW:0]    C_DEPTH_L = (C_CW+1)'(C_DEPTH);
  localparam logic [0:0]       S_FETCH   = 1'b0;
  localparam logic [0:0]       S_HALT    = 1'b1;

  logic [0:0]                r_state, w_state_nxt;
  logic [C_XLEN-1:0]         r_fetch_pc, r_resp_pc;
  logic [C_CW-1:0]           r_cnt, r_out, r_disc;
  logic [C_FIFO_DEPTH_X-1:0] r_wptr, r_rptr;
  logic                      r_sof_pend;
  logic                      r_aerr;

  logic [31:0]               r_ins  [C_DEPTH];
  logic [C_XLEN-1:0]         r_pc   [C_DEPTH];
  logic                      r_ferr [C_DEPTH];
  logic [`SOFID_RANGE]       r_sof  [C_DEPTH];

  logic              w_vec, w_acc, w_rv, w_drop, w_push, w_pop, w_misalign;
  logic              w_push_ferr;
  logic [31:0]       w_push_ins;
  logic [C_XLEN-1:0] w_tgt, w_rpc_tgt;
  logic [C_CW:0]     w_level;

`ifdef PFU_ALIGN_CHECK_EN
  assign w_misalign = exs_pc_wr_i & (exs_pc_i[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif
  assign w_tgt      = exs_pc_i & ~{{(C_XLEN-2){1'b0}}, 2'b11};
  // A misaligned target is reported with its original address.
  assign w_rpc_tgt  = w_misalign ? exs_pc_i : w_tgt;

  assign w_vec       = exs_pc_wr_i;
  assign w_acc       = imem_req_o & imem_gnt_i;
  assign w_rv        = imem_rvalid_i;
  assign w_drop      = (r_disc != '0);
  assign w_push      = ((w_rv & ~w_drop) | r_aerr) & ~w_vec;
  assign w_pop       = ids_ack_i & ids_dav_o & ~w_vec;
  assign w_push_ferr = r_aerr | imem_rerr_i;
  assign w_push_ins  = r_aerr ? 32'h0 : imem_rdata_i;
  assign w_level     = {1'b0, r_cnt} + {1'b0, r_out};

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_state <= S_FETCH;
    end else if (clk_en_i) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_vec) begin
      w_state_nxt = w_misalign ? S_HALT : S_FETCH;
    end else if (w_push & w_push_ferr) begin
      w_state_nxt = S_HALT;
    end
  end

  // Gating on the registered count keeps out_q within the free FIFO space.
  always_comb begin
    imem_req_o = resetb_i & clk_en_i & ~exs_pc_wr_i &
                 (r_state == S_FETCH) & (w_level < C_DEPTH_L);
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_fetch_pc <= C_RESET_VECTOR;
      r_resp_pc  <= C_RESET_VECTOR;
      r_cnt      <= '0;
      r_out      <= '0;
      r_disc     <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_sof_pend <= 1'b1;
      r_aerr     <= 1'b0;
    end else if (clk_en_i) begin
      if (w_vec) begin
        // Everything still in flight after this cycle belongs to the old stream.
        r_fetch_pc <= w_tgt;
        r_resp_pc  <= w_rpc_tgt;
        r_cnt      <= '0;
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_out      <= r_out - C_CW'(w_rv);
        r_disc     <= r_out - C_CW'(w_rv);
        r_sof_pend <= 1'b1;
        r_aerr     <= w_misalign;
      end else begin
        r_aerr <= 1'b0;
        r_out  <= r_out + C_CW'(w_acc) - C_CW'(w_rv);
        r_cnt  <= r_cnt + C_CW'(w_push) - C_CW'(w_pop);
        if (w_acc) begin
          r_fetch_pc <= r_fetch_pc + C_XLEN'(4);
        end
        if (w_rv & w_drop) begin
          r_disc <= r_disc - C_CW'(1);
        end
        if (w_push) begin
          r_wptr     <= r_wptr + C_FIFO_DEPTH_X'(1);
          r_resp_pc  <= r_resp_pc + C_XLEN'(4);
          r_sof_pend <= 1'b0;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + C_FIFO_DEPTH_X'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clk_en_i & w_push) begin
      r_ins[r_wptr]  <= w_push_ins;
      r_pc[r_wptr]   <= r_resp_pc;
      r_ferr[r_wptr] <= w_push_ferr;
      r_sof[r_wptr]  <= r_sof_pend ? `SOFID_JUMP : `SOFID_RUN;
    end
  end

  assign ids_dav_o   = (r_cnt != '0);
  assign ids_ins_o   = r_ins[r_rptr];
  assign ids_pc_o    = r_pc[r_rptr];
  assign ids_ferr_o  = r_ferr[r_rptr];
  assign ids_sofid_o = r_sof[r_rptr];
  assign imem_addr_o = r_fetch_pc;

endmodule

`default_nettype wire

// File: tb/tb_pfu.sv
`default_nettype none
// tb_pfu : directed vector table plus hand sequences for the prefetch unit.
`ifndef SOFID_RANGE
`define SOFID_RANGE 1:0
`define SOFID_RUN   2'b00
`define SOFID_JUMP  2'b01
`endif

module tb_pfu;

  logic        clk = 1'b0;
  logic        clk_en, resetb, vec, dav, ack, ferr, req, gnt, rvalid, rerr;
  logic [31:0] vec_pc, ins, pc, addr, rdata;
  logic [1:0]  sof;

  always #5 clk = ~clk;

  pfu dut (
    .clk_i(clk), .clk_en_i(clk_en), .resetb_i(resetb),
    .exs_pc_wr_i(vec), .exs_pc_i(vec_pc),
    .ids_dav_o(dav), .ids_ack_i(ack), .ids_sofid_o(sof), .ids_ins_o(ins),
    .ids_ferr_o(ferr), .ids_pc_o(pc),
    .imem_req_o(req), .imem_gnt_i(gnt), .imem_addr_o(addr),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .imem_rerr_i(rerr)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] q[$];
  logic        hold;
  logic [31:0] err_addr;

  typedef struct {
    logic        ack;
    logic        dav;
    logic [31:0] pc;
    logic [1:0]  sof;
    logic        req;
    logic [31:0] addr;
  } vec_t;
  vec_t tbl[13];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a << 12) | 32'h13;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: memory accepts on req&gnt and answers in order one cycle later.
  task automatic tick();
    logic        acc, rv;
    logic [31:0] a;
    acc = req & gnt;
    rv  = rvalid & clk_en;
    a   = addr;
    @(posedge clk);
    #1;
    if (rv && q.size() > 0) q.delete(0);
    if (acc) q.push_back(a);
    if (!hold && q.size() > 0) begin
      rvalid = 1'b1;
      rdata  = mem(q[0]);
      rerr   = (q[0] == err_addr);
    end else begin
      rvalid = 1'b0;
      rdata  = 32'h0;
      rerr   = 1'b0;
    end
  endtask

  task automatic wait_dav(input string name);
    int n;
    n = 0;
    while (!dav && n < 50) begin
      tick();
      #1;
      n++;
    end
    chk({name, " dav timeout"}, 32'(dav), 32'd1);
  endtask

  task automatic do_vec(input logic [31:0] t);
    vec    = 1'b1;
    vec_pc = t;
    #1;
    chk("vector cycle req", 32'(req), 32'd0);
    tick();
    vec = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32'h00, `SOFID_RUN,  1'b1, 32'h00};
    tbl[1]  = '{1'b1, 1'b0, 32'h00, `SOFID_RUN,  1'b1, 32'h04};
    tbl[2]  = '{1'b1, 1'b1, 32'h00, `SOFID_JUMP, 1'b1, 32'h08};
    tbl[3]  = '{1'b1, 1'b1, 32'h04, `SOFID_RUN,  1'b1, 32'h0C};
    tbl[4]  = '{1'b1, 1'b1, 32'h08, `SOFID_RUN,  1'b1, 32'h10};
    tbl[5]  = '{1'b1, 1'b1, 32'h0C, `SOFID_RUN,  1'b1, 32'h14};
    tbl[6]  = '{1'b0, 1'b1, 32'h10, `SOFID_RUN,  1'b1, 32'h18};
    tbl[7]  = '{1'b0, 1'b1, 32'h10, `SOFID_RUN,  1'b1, 32'h1C};
    tbl[8]  = '{1'b0, 1'b1, 32'h10, `SOFID_RUN,  1'b0, 32'h20};
    tbl[9]  = '{1'b0, 1'b1, 32'h10, `SOFID_RUN,  1'b0, 32'h20};
    tbl[10] = '{1'b1, 1'b1, 32'h10, `SOFID_RUN,  1'b0, 32'h20};
    tbl[11] = '{1'b1, 1'b1, 32'h14, `SOFID_RUN,  1'b1, 32'h20};
    tbl[12] = '{1'b1, 1'b1, 32'h18, `SOFID_RUN,  1'b1, 32'h24};

    clk_en = 1'b1; resetb = 1'b0; vec = 1'b0; vec_pc = 32'h0; ack = 1'b0;
    gnt = 1'b1; hold = 1'b0; err_addr = 32'hFFFF_FFFC;
    rvalid = 1'b0; rdata = 32'h0; rerr = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset dav", 32'(dav), 32'd0);
    chk("reset req", 32'(req), 32'd0);
    resetb = 1'b1;

    // Streaming from the reset vector, then id stalls until the FIFO fills.
    for (int i = 0; i < 13; i++) begin
      ack = tbl[i].ack;
      #1;
      chk($sformatf("t%0d dav", i), 32'(dav), 32'(tbl[i].dav));
      chk($sformatf("t%0d req", i), 32'(req), 32'(tbl[i].req));
      chk($sformatf("t%0d addr", i), addr, tbl[i].addr);
      if (tbl[i].dav) begin
        chk($sformatf("t%0d pc", i), pc, tbl[i].pc);
        chk($sformatf("t%0d sof", i), 32'(sof), 32'(tbl[i].sof));
        chk($sformatf("t%0d ins", i), ins, mem(tbl[i].pc));
        chk($sformatf("t%0d ferr", i), 32'(ferr), 32'd0);
      end
      tick();
    end

    // Vector with two responses outstanding: both must be dropped.
    ack = 1'b0; gnt = 1'b0;
    do_vec(32'h40);
    chk("A flush dav", 32'(dav), 32'd0);
    chk("A addr", addr, 32'h40);
    hold = 1'b1; gnt = 1'b1;
    tick(); #1;
    tick(); #1;
    gnt = 1'b0;
    chk("A two issued", addr, 32'h48);
    do_vec(32'h100);
    chk("A vec addr", addr, 32'h100);
    chk("A vec dav", 32'(dav), 32'd0);
    hold = 1'b0; gnt = 1'b1;
    wait_dav("A");
    chk("A pc", pc, 32'h100);
    chk("A sof", 32'(sof), 32'(`SOFID_JUMP));
    chk("A ins", ins, mem(32'h100));
    ack = 1'b1;
    tick(); #1;
    wait_dav("A2");
    chk("A2 pc", pc, 32'h104);
    chk("A2 sof", 32'(sof), 32'(`SOFID_RUN));

    // Bus error on the response for 0x8 halts fetching.
    err_addr = 32'h8; ack = 1'b0; gnt = 1'b0;
    do_vec(32'h0);
    for (int k = 0; k < 8 && q.size() > 0; k++) begin
      tick(); #1;
    end
    gnt = 1'b1; ack = 1'b1;
    for (int j = 0; j < 4; j++) begin
      logic [31:0] epc;
      epc = 32'(j) * 32'd4;
      wait_dav($sformatf("B%0d", j));
      chk($sformatf("B%0d pc", j), pc, epc);
      chk($sformatf("B%0d ferr", j), 32'(ferr), (epc == 32'h8) ? 32'd1 : 32'd0);
      if (j == 0) chk("B0 sof", 32'(sof), 32'(`SOFID_JUMP));
      tick(); #1;
    end
    begin
      int nreq;
      nreq = 0;
      for (int k = 0; k < 8; k++) begin
        if (req) nreq++;
        tick(); #1;
      end
      chk("B halted req count", 32'(nreq), 32'd0);
      chk("B halted dav", 32'(dav), 32'd0);
    end

    // Resume at 0x200; vector-to-dav latency is three cycles.
    ack = 1'b0;
    do_vec(32'h200);
    chk("C resume req", 32'(req), 32'd1);
    chk("C resume addr", addr, 32'h200);
    tick(); #1;
    chk("C latency2 dav", 32'(dav), 32'd0);
    tick(); #1;
    chk("C latency3 dav", 32'(dav), 32'd1);
    chk("C pc", pc, 32'h200);
    chk("C sof", 32'(sof), 32'(`SOFID_JUMP));
    for (int k = 0; k < 10 && req; k++) begin
      tick(); #1;
    end
    chk("C full req", 32'(req), 32'd0);
    repeat (3) begin
      tick(); #1;
    end
    clk_en = 1'b0; ack = 1'b1;
    tick(); #1;
    tick(); #1;
    chk("C clk_en hold pc", pc, 32'h200);
    chk("C clk_en hold dav", 32'(dav), 32'd1);
    clk_en = 1'b1;
    #1;
    chk("C full+ack req", 32'(req), 32'd0);
    tick(); #1;
    chk("C after pop pc", pc, 32'h204);
    chk("C after pop req", 32'(req), 32'd1);
    ack = 1'b0;
    repeat (3) begin
      tick(); #1;
    end
    chk("C refill req", 32'(req), 32'd0);
    ack = 1'b1;
    do_vec(32'h300);
    chk("C vec+ack dav", 32'(dav), 32'd0);
    wait_dav("C3");
    chk("C3 pc", pc, 32'h300);
    chk("C3 sof", 32'(sof), 32'(`SOFID_JUMP));

    // Misaligned vector target.
    ack = 1'b0;
    do_vec(32'h102);
`ifdef PFU_ALIGN_CHECK_EN
    chk("D req", 32'(req), 32'd0);
    chk("D dav early", 32'(dav), 32'd0);
    tick(); #1;
    chk("D dav", 32'(dav), 32'd1);
    chk("D pc", pc, 32'h102);
    chk("D ferr", 32'(ferr), 32'd1);
    chk("D ins", ins, 32'h0);
    chk("D sof", 32'(sof), 32'(`SOFID_JUMP));
    ack = 1'b1;
    tick(); #1;
    chk("D single entry", 32'(dav), 32'd0);
    chk("D halted req", 32'(req), 32'd0);
`else
    chk("D req", 32'(req), 32'd1);
    chk("D addr", addr, 32'h100);
    wait_dav("D");
    chk("D pc", pc, 32'h100);
    chk("D ferr", 32'(ferr), 32'd0);
    chk("D ins", ins, mem(32'h100));
    chk("D sof", 32'(sof), 32'(`SOFID_JUMP));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pfu.md
# pfu

Prefetch unit for the rv32i core. Issues word fetches to the instruction memory port, buffers returned instructions in a small FIFO, and presents them one at a time to the instruction decode stage over a dav/ack handshake. On a vector request from the execute stage it flushes the buffer, discards in-flight responses, and restarts fetching at the new address, tagging the first instruction delivered after the vector.

## Interface
- C_XLEN, 32, data/address width
- C_FIFO_DEPTH_X, 2, log2 of instruction buffer depth (4 entries)
- C_RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- clk_i  input  1  core clock
- clk_en_i  input  1  global clock enable; all state holds when low
- resetb_i  input  1  reset; asynchronous, active-low
- exs_pc_wr_i  input  1  vector request from ex stage
- exs_pc_i  input  C_XLEN  vector target address
- ids_dav_o  output  1  instruction available to id stage
- ids_ack_i  input  1  id stage consumes head entry
- ids_sofid_o  output  `SOFID_RANGE  `SOFID_JUMP on first entry after reset/vector, else `SOFID_RUN
- ids_ins_o  output  32  instruction word
- ids_ferr_o  output  1  fetch error for this entry
- ids_pc_o  output  32  address of this entry
- imem_req_o  output  1  fetch request
- imem_gnt_i  input  1  request accepted this cycle
- imem_addr_o  output  32  fetch address (word aligned)
- imem_rvalid_i  input  1  response valid
- imem_rdata_i  input  32  response data
- imem_rerr_i  input  1  response bus error

## Operation
- State: fetch_pc_q, FIFO (ins, pc, ferr, sofid), outstanding counter out_q, discard counter disc_q, sof_pending_q, FSM {FETCH, HALT}.
- imem_req_o = (state==FETCH) & (FIFO count + out_q < depth). imem_addr_o = fetch_pc_q.
- On req&gnt: fetch_pc_q += 4; out_q++. Response pc tracked via a response-pc register advancing by 4 per accepted response.
- On rvalid: out_q--; if disc_q>0, disc_q-- and drop; else write FIFO entry with sofid=`SOFID_JUMP if sof_pending_q (then clear), ferr=imem_rerr_i.
- Response with imem_rerr_i written to FIFO, FSM -> HALT; no further requests until vector.
- ids_dav_o = FIFO not empty; head fields drive ids_*_o; ids_ack_i pops (ack without dav ignored).
- Vector (exs_pc_wr_i): FIFO flushed; disc_q += out_q (minus any response arriving same cycle is itself discarded); fetch_pc_q and response-pc <= exs_pc_i; sof_pending_q <= 1; FSM -> FETCH. Vector overrides simultaneous ack, gnt-increment, and FIFO write.
- Arithmetic: pc increments wrap modulo 2^32.

## Timing
- Reset: ids_dav_o=0, imem_req_o=0 during reset; fetch_pc_q=C_RESET_VECTOR, sof_pending_q=1, out_q=disc_q=0, FSM=FETCH; imem_req_o=1 first cycle after release.
- Vector at cycle N: imem_addr_o=target from N+1; requests in cycle N are suppressed.
- Response write at cycle M -> ids_dav_o high M+1 (no bypass). Minimum vector-to-dav latency: 3 cycles with single-cycle gnt/rvalid.
- Full FIFO with ack same cycle: space not reused for request until next cycle (request gating uses registered count).
- Simultaneous pop and push: count unchanged, both performed.
- Reset mid-operation: all state cleared immediately; late responses after reset are ignored only if out_q reflects them—memory port is reset by the same resetb_i.

## Configuration
- PFU_ALIGN_CHECK_EN defined: vector with exs_pc_i[1:0]!=0 issues no request; one FIFO entry written next cycle with ferr=1, ins=0, pc=exs_pc_i, sofid=`SOFID_JUMP; FSM -> HALT.
- Undefined: exs_pc_i[1:0] ignored; fetch at {exs_pc_i[31:2],2'b00}, reported pc equals masked address.

## Test plan
- Reset release, memory returns 0x00000013 per word, id acks every cycle -> ids_pc_o 0x0,0x4,0x8…; first entry sofid=`SOFID_JUMP, rest `SOFID_RUN.
- id holds ids_ack_i=0 -> exactly 4 entries buffered, imem_req_o deasserts, out_q never exceeds free space.
- Vector to 0x100 with 2 requests outstanding -> those 2 responses dropped; next dav entry pc=0x100, sofid=`SOFID_JUMP.
- imem_rerr_i on response for 0x8 -> entry pc=0x8 ferr=1, no further requests until vector to 0x200 resumes fetching.
- Vector and ids_ack_i same cycle with FIFO full -> FIFO empty next cycle, ids_dav_o=0.
- With PFU_ALIGN_CHECK_EN, vector to 0x102 -> no imem_req_o, single entry pc=0x102 ferr=1; without, fetch at 0x100.
